// File: rtl/hdmi_text_pixel_pipe.sv
// Text-mode pixel renderer: drawX/drawY -> VRAM word -> font row -> RGB444, three-cycle pipeline.
// Optional blink of inverted cells is built when the TEXT_BLINK_EN macro is defined.
module hdmi_text_pixel_pipe #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned VRAM_AW   = 10,
  parameter int unsigned BLINK_BIT = 5
) (
  input  logic               pixel_clk,
  input  logic               reset_ah,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               vde_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [31:0]        vram_rdata,
  output logic [10:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic [31:0]        ctrl_reg,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               vde_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int unsigned IdxW = $clog2(COLS * ROWS);

  logic [6:0]      col;
  logic [4:0]      row;
  logic [IdxW-1:0] idx;

  // S1 stage
  logic [1:0] s1_sel_q;
  logic [2:0] s1_px_q;
  logic [3:0] s1_row_q;
  logic       s1_vde_q, s1_hs_q, s1_vs_q;
  logic [7:0] char_byte;

  // S2 stage
  logic       s2_inv_q;
  logic [2:0] s2_px_q;
  logic       s2_vde_q, s2_hs_q, s2_vs_q;

  logic        pix_on;
  logic        hide;
  logic [11:0] rgb_d;

  logic unused_bits;
  assign unused_bits = ^{drawY[9], ctrl_reg[31:25], ctrl_reg[0], (BLINK_BIT == 0)};

  always_comb begin
    col = drawX[9:3];
    row = drawY[8:4];
    // Out-of-range coordinates simply produce a truncated address.
    idx = IdxW'(row) * IdxW'(COLS) + IdxW'(col);
    vram_addr = reset_ah ? '0 : VRAM_AW'(idx >> 2);
  end

  always_comb begin
    char_byte = vram_rdata[8*s1_sel_q +: 8];
    font_addr = reset_ah ? '0 : {char_byte[6:0], s1_row_q};
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_q;
  logic       vsync_prev_q;

  always_ff @(posedge pixel_clk) begin
    if (reset_ah) begin
      frame_q      <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_in;
      if (vsync_prev_q && !vsync_in) frame_q <= frame_q + 6'd1;
    end
  end

  assign hide = frame_q[BLINK_BIT] & s2_inv_q;
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    pix_on = font_data[3'd7 - s2_px_q] ^ s2_inv_q;
    if (!s2_vde_q)            rgb_d = '0;
    else if (pix_on && !hide) rgb_d = ctrl_reg[24:13];
    else                      rgb_d = ctrl_reg[12:1];
  end

  always_ff @(posedge pixel_clk) begin
    if (reset_ah) begin
      s1_sel_q  <= '0;
      s1_px_q   <= '0;
      s1_row_q  <= '0;
      s1_vde_q  <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s2_inv_q  <= 1'b0;
      s2_px_q   <= '0;
      s2_vde_q  <= 1'b0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      vde_out   <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      s1_sel_q  <= idx[1:0];
      s1_px_q   <= drawX[2:0];
      s1_row_q  <= drawY[3:0];
      s1_vde_q  <= vde_in;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      s2_inv_q  <= char_byte[7];
      s2_px_q   <= s1_px_q;
      s2_vde_q  <= s1_vde_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      {red, green, blue} <= rgb_d;
      vde_out   <= s2_vde_q;
      hsync_out <= s2_hs_q;
      vsync_out <= s2_vs_q;
    end
  end

endmodule

// File: tb/tb_hdmi_text_pixel_pipe.sv
// Directed bench for hdmi_text_pixel_pipe with behavioural VRAM and font ROM (1-cycle read latency).
module tb_hdmi_text_pixel_pipe;

  localparam logic [11:0] FG = 12'hF00;
  localparam logic [11:0] BG = 12'h00F;

  logic        clk = 1'b0;
  logic        reset_ah = 1'b1;
  logic [9:0]  drawX = '0, drawY = '0;
  logic        vde_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [31:0] ctrl_reg = {7'b0, FG, BG, 1'b0};
  logic [3:0]  red, green, blue;
  logic        vde_out, hsync_out, vsync_out;
  wire  [11:0] rgb = {red, green, blue};

  logic [31:0] vram [1024];
  logic [7:0]  font [2048];

  int checks = 0;
  int errors = 0;

  hdmi_text_pixel_pipe dut (
    .pixel_clk (clk),
    .reset_ah  (reset_ah),
    .drawX     (drawX),
    .drawY     (drawY),
    .vde_in    (vde_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .vram_addr (vram_addr),
    .vram_rdata(vram_rdata),
    .font_addr (font_addr),
    .font_data (font_data),
    .ctrl_reg  (ctrl_reg),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .vde_out   (vde_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_rdata <= vram[vram_addr];
    font_data  <= font[font_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input logic v, input logic h, input logic s);
    drawX    = 10'(x);
    drawY    = 10'(y);
    vde_in   = v;
    hsync_in = h;
    vsync_in = s;
  endtask

  task automatic test_reset();
    reset_ah = 1'b1;
    set_pix(100, 100, 1'b1, 1'b1, 1'b1);
    repeat (3) next_cycle();
    checks++;
    if (rgb !== 12'h000 || vde_out !== 1'b0 || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rgb=%h vde=%b hs=%b vs=%b, required all 0",
               rgb, vde_out, hsync_out, vsync_out);
    end
    checks++;
    if (vram_addr !== 10'd0 || font_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_addrs: vram_addr=%0d font_addr=%h, required 0/0", vram_addr, font_addr);
    end
    reset_ah = 1'b0;
    set_pix(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_plain();
    logic [11:0] exp [8];
    exp = '{BG, BG, BG, FG, FG, BG, BG, BG};
    vram[0] = 32'h0000_0041;
    font[11'h410] = 8'h18;
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      if (i >= 3) begin
        checks++;
        if (rgb !== exp[i-3] || vde_out !== 1'b1) begin
          errors++;
          $display("FAIL plain_px%0d: rgb=%h vde=%b, required rgb=%h vde=1",
                   i - 3, rgb, vde_out, exp[i-3]);
        end
      end
      if (i < 8) set_pix(i, 0, 1'b1, 1'b0, 1'b0);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_inverse();
    logic [11:0] exp [8];
    exp = '{FG, FG, FG, BG, BG, FG, FG, FG};
    vram[0] = 32'h0000_8100;
    font[11'h010] = 8'h18;
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      if (i >= 3) begin
        checks++;
        if (rgb !== exp[i-3]) begin
          errors++;
          $display("FAIL inverse_px%0d: rgb=%h, required %h", i + 5, rgb, exp[i-3]);
        end
      end
      if (i < 8) set_pix(8 + i, 0, 1'b1, 1'b0, 1'b0);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_boundary();
    vram[599] = 32'h5A00_0000;
    font[{7'h5A, 4'hF}] = 8'h01;
    next_cycle();
    set_pix(639, 479, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (vram_addr !== 10'd599) begin
      errors++;
      $display("FAIL edge_vram_addr: got %0d, required 599", vram_addr);
    end
    next_cycle();
    checks++;
    if (font_addr !== {7'h5A, 4'hF}) begin
      errors++;
      $display("FAIL edge_font_addr: got %h, required %h", font_addr, {7'h5A, 4'hF});
    end
    set_pix(640, 479, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_pix(641, 479, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++;
    if (rgb !== FG || vde_out !== 1'b1) begin
      errors++;
      $display("FAIL edge_last_px: rgb=%h vde=%b, required rgb=%h vde=1", rgb, vde_out, FG);
    end
    next_cycle();
    checks++;
    if (rgb !== 12'h000 || vde_out !== 1'b0) begin
      errors++;
      $display("FAIL edge_blank: rgb=%h vde=%b, required 000/0", rgb, vde_out);
    end
    set_pix(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timing();
    logic [2:0] pat [16];
    pat = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b001, 3'b000, 3'b111, 3'b101,
            3'b010, 3'b001, 3'b100, 3'b011, 3'b000, 3'b110, 3'b101, 3'b010};
    for (int i = 0; i < 19; i++) begin
      next_cycle();
      if (i >= 3) begin
        checks++;
        if ({vde_out, hsync_out, vsync_out} !== pat[i-3] ||
            (!pat[i-3][2] && rgb !== 12'h000)) begin
          errors++;
          $display("FAIL timing_step%0d: vde/hs/vs=%b rgb=%h, required %b",
                   i - 3, {vde_out, hsync_out, vsync_out}, rgb, pat[i-3]);
        end
      end
      if (i < 16) set_pix(700, 500, pat[i][2], pat[i][1], pat[i][0]);
      else        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp [8];
    exp = '{BG, BG, BG, FG, FG, BG, BG, BG};
    vram[0] = 32'h0000_0041;
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      if (i >= 2 && i <= 4) begin
        checks++;
        if (rgb !== 12'h000 || vde_out !== 1'b0 || hsync_out !== 1'b0) begin
          errors++;
          $display("FAIL midreset_zero%0d: rgb=%h vde=%b hs=%b, required 000/0/0",
                   i, rgb, vde_out, hsync_out);
        end
      end else if (i >= 5) begin
        checks++;
        if (rgb !== exp[i-3] || vde_out !== 1'b1 || hsync_out !== 1'b1) begin
          errors++;
          $display("FAIL midreset_px%0d: rgb=%h vde=%b hs=%b, required rgb=%h vde=1 hs=1",
                   i - 3, rgb, vde_out, hsync_out, exp[i-3]);
        end
      end
      if (i < 8) set_pix(i, 0, 1'b1, 1'b1, 1'b0);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      reset_ah = (i == 1);
    end
    reset_ah = 1'b0;
  endtask

`ifdef TEXT_BLINK_EN
  task automatic test_blink();
    logic [11:0] exp_hidden [8];
    logic [11:0] exp_inv [8];
    exp_hidden = '{BG, BG, BG, BG, BG, BG, BG, BG};
    exp_inv    = '{FG, FG, FG, BG, BG, FG, FG, FG};
    vram[0] = 32'h0000_8100;
    for (int phase = 0; phase < 2; phase++) begin
      for (int e = 0; e < 32; e++) begin
        next_cycle();
        set_pix(0, 0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 11; i++) begin
        next_cycle();
        if (i >= 3) begin
          checks++;
          if (rgb !== (phase == 0 ? exp_hidden[i-3] : exp_inv[i-3])) begin
            errors++;
            $display("FAIL blink_phase%0d_px%0d: rgb=%h, required %h", phase, i + 5, rgb,
                     (phase == 0 ? exp_hidden[i-3] : exp_inv[i-3]));
          end
        end
        if (i < 8) set_pix(8 + i, 0, 1'b1, 1'b0, 1'b0);
        else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 1024; a++) vram[a] = '0;
    for (int a = 0; a < 2048; a++) font[a] = '0;
    test_reset();
    test_plain();
    test_inverse();
    test_boundary();
    test_timing();
    test_reset_mid();
`ifdef TEXT_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
